mdu_ctrl: RTL

Issue and sequencing controller for the multi-cycle multiply/divide unit (MDU) in the E stage. It classifies the E-stage MDU opcode, fires a one-cycle start strobe, counts the op-dependent latency and commits results with single-cycle write enables. It also generates the D-stage stall and E-stage hold that keep the pipeline consistent. Exception/interrupt requests (`req`) gate issue and abort in-flight `mul`.

---
 rtl/mdu_ctrl_pkg.sv | 42 ++++
 rtl/mdu_ctrl_if.sv | 35 +++
 rtl/mdu_ctrl_op_class.sv | 30 +++
 rtl/mdu_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU opcode codes, default latencies, controller state and op-class types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_ctrl_pkg;

    typedef logic [4:0] mdu_op_t;

    // E-stage MDU opcodes; anything not listed here is a non-MDU instruction.
    localparam mdu_op_t MDU_NONE  = 5'd0;
    localparam mdu_op_t MDU_MULT  = 5'd1;
    localparam mdu_op_t MDU_MULTU = 5'd2;
    localparam mdu_op_t MDU_MADD  = 5'd3;
    localparam mdu_op_t MDU_MADDU = 5'd4;
    localparam mdu_op_t MDU_MSUB  = 5'd5;
    localparam mdu_op_t MDU_MSUBU = 5'd6;
    localparam mdu_op_t MDU_MUL   = 5'd7;
    localparam mdu_op_t MDU_DIV   = 5'd8;
    localparam mdu_op_t MDU_DIVU  = 5'd9;
    localparam mdu_op_t MDU_MTHI  = 5'd10;
    localparam mdu_op_t MDU_MTLO  = 5'd11;
    localparam mdu_op_t MDU_MFHI  = 5'd12;
    localparam mdu_op_t MDU_MFLO  = 5'd13;

    // Default start-to-commit latencies shared with the datapath.
    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic long_m;
        logic long_d;
        logic move_hi;
        logic move_lo;
        logic read;
        logic is_mul;
    } op_class_t;

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> MDU controller bundle: E/D-stage status in, strobes and stalls out.
// Latency: n/a (wiring only).
// Backpressure: stall_d/hold_e flow from controller to pipeline.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic    e_valid;
    mdu_op_t e_op;
    logic    d_is_mdu;
    logic    req;

    logic    mdu_start;
    mdu_op_t mdu_op_q;
    logic    hilo_we;
    logic    mul_we;
    logic    hi_we;
    logic    lo_we;
    logic    busy;
    logic    stall_d;
    logic    hold_e;

    // Pipeline side drives stage status and observes control.
    modport master (
        output e_valid, e_op, d_is_mdu, req,
        input  mdu_start, mdu_op_q, hilo_we, mul_we, hi_we, lo_we,
               busy, stall_d, hold_e
    );

    // Controller side.
    modport slave (
        input  e_valid, e_op, d_is_mdu, req,
        output mdu_start, mdu_op_q, hilo_we, mul_we, hi_we, lo_we,
               busy, stall_d, hold_e
    );
endinterface

// File: rtl/mdu_ctrl_op_class.sv
// Combinational classifier of the E-stage MDU opcode.
// Latency: 0 cycles (pure decode).
// Backpressure: none.
module mdu_op_class
    import mdu_ctrl_pkg::*;
(
    input  mdu_op_t   e_op_i,
    output op_class_t cls_o
);

    // Map each opcode onto its class flags; unknown codes decode to nothing.
    always_comb begin
        cls_o = '0;
        unique case (e_op_i)
            MDU_MULT, MDU_MULTU,
            MDU_MADD, MDU_MADDU,
            MDU_MSUB, MDU_MSUBU: cls_o.long_m = 1'b1;
            MDU_MUL: begin
                cls_o.long_m = 1'b1;
                cls_o.is_mul = 1'b1;
            end
            MDU_DIV, MDU_DIVU:   cls_o.long_d  = 1'b1;
            MDU_MTHI:            cls_o.move_hi = 1'b1;
            MDU_MTLO:            cls_o.move_lo = 1'b1;
            MDU_MFHI, MDU_MFLO:  cls_o.read    = 1'b1;
            default:             cls_o         = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU issue/sequencing controller: start strobe, latency count, commit strobes, D stall, E hold.
// Latency: commit MUL_LAT/DIV_LAT cycles after the start strobe; moves write in the issue cycle.
// Backpressure: stall_d freezes D while busy or issuing; hold_e keeps an in-flight mul in E.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MDU_MUL_LAT,
    parameter int DIV_LAT = MDU_DIV_LAT
) (
    input  logic     clk,
    input  logic     reset,
    mdu_ctrl_if.slave mdu
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    mdu_state_e state_q;
    logic [3:0] cnt_q;
    mdu_op_t    op_q;

    op_class_t  cls;
    logic       idle;
    logic       issue;
    logic       commit;
    logic       run_mul;
    logic       unused_read;

    mdu_op_class u_op_class (
        .e_op_i (mdu.e_op),
        .cls_o  (cls)
    );

    // Reads of HI/LO need no controller action; the class flag is left unused.
    assign unused_read = cls.read;

    assign idle    = (state_q == ST_IDLE);
    assign issue   = idle & mdu.e_valid & (cls.long_m | cls.long_d) & ~mdu.req;
    assign commit  = (state_q == ST_RUN) & (cnt_q == 4'd0);
    assign run_mul = (state_q == ST_RUN) & (op_q == MDU_MUL);

    // Issue/count/commit state machine; a flush aborts only an in-flight mul.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= MDU_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        op_q    <= mdu.e_op;
                        cnt_q   <= cls.long_d ? DIV_CNT : MUL_CNT;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((run_mul && mdu.req) || cnt_q == 4'd0) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mdu.mdu_start = issue;
    assign mdu.mdu_op_q  = op_q;
    assign mdu.busy      = (state_q == ST_RUN);
    // HI/LO ops are older than any flush and always commit; mul is squashed by req.
    assign mdu.hilo_we   = commit & (op_q != MDU_MUL);
    assign mdu.mul_we    = commit & (op_q == MDU_MUL) & ~mdu.req;
    assign mdu.hi_we     = idle & mdu.e_valid & cls.move_hi & ~mdu.req;
    assign mdu.lo_we     = idle & mdu.e_valid & cls.move_lo & ~mdu.req;
    assign mdu.stall_d   = mdu.d_is_mdu & (mdu.busy | issue);
    // Hold drops in the commit cycle so the mul leaves E on that edge.
    assign mdu.hold_e    = (issue & cls.is_mul) | (run_mul & (cnt_q != 4'd0));

endmodule
